// File: rtl/axi_width_downsizer_trim.sv
// AXI4-Stream width downsizer with trailing-empty-sub-word trimming.
// Each wide input beat is split into RATIO narrow beats, least-significant
// sub-word first. On a tlast beat, sub-words above the last one carrying any
// tkeep bit are dropped, so zero padding added by an upsizer is not replayed.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where tvalid and tready are both high; a source never drops tvalid or
// changes its payload while tvalid=1 and tready=0. in_tready_o depends
// combinationally on out_tready_i so a new wide beat is taken in the same
// cycle the final narrow beat leaves, keeping full throughput.
module axi_width_downsizer_trim #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 256
) (
  input  logic                                     clk,
  input  logic                                     rst,
  // wide input stream
  input  logic [IN_WIDTH-1:0]                      in_tdata_i,
  input  logic [IN_WIDTH/8-1:0]                    in_tkeep_i,
  input  logic                                     in_tlast_i,
  input  logic                                     in_tvalid_i,
  output logic                                     in_tready_o,
  // narrow output stream
  output logic [OUT_WIDTH-1:0]                     out_tdata_o,
  output logic [OUT_WIDTH/8-1:0]                   out_tkeep_o,
  output logic                                     out_tlast_o,
  output logic                                     out_tvalid_o,
  input  logic                                     out_tready_i,
  // internal state, exposed for checkers
  output logic                                     dbg_full_o,
  output logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0]    dbg_idx_o
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(RATIO);
  localparam int OKB   = OUT_WIDTH / 8;
  localparam int IKB   = IN_WIDTH / 8;

  // Reject illegal width combinations at elaboration time.
  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0 ||
      (OUT_WIDTH % 8) != 0) begin : g_bad_params
    $error("axi_width_downsizer_trim: IN_WIDTH/OUT_WIDTH must be a power of two >= 2 and OUT_WIDTH a multiple of 8");
  end

  logic [IN_WIDTH-1:0] hold_data_q;
  logic [IKB-1:0]      hold_keep_q;
  logic                hold_last_q;
  logic                full_q;
  logic [IDX_W-1:0]    idx_q;

  logic [RATIO-1:0]    sub_nz;
  logic                upper_nz;
  logic                fin;
  logic                in_hs;
  logic                out_hs;

  // Per-sub-word "has any keep bit" flags, and whether any sub-word above idx has one.
  always_comb begin
    sub_nz   = '0;
    upper_nz = 1'b0;
    for (int s = 0; s < RATIO; s++) begin
      sub_nz[s] = |hold_keep_q[s*OKB +: OKB];
      if (s > int'(idx_q) && sub_nz[s]) begin
        upper_nz = 1'b1;
      end
    end
  end

  // Current sub-beat is the last one of the held beat: top sub-word, or a
  // tlast beat with nothing but empty sub-words above it.
  assign fin = (idx_q == IDX_W'(RATIO - 1)) || (hold_last_q && !upper_nz);

  assign out_tvalid_o = full_q;
  assign out_tdata_o  = hold_data_q[int'(idx_q)*OUT_WIDTH +: OUT_WIDTH];
  assign out_tkeep_o  = hold_keep_q[int'(idx_q)*OKB +: OKB];
  assign out_tlast_o  = hold_last_q && fin;
  assign in_tready_o  = !full_q || (out_tready_i && fin);

  assign in_hs  = in_tvalid_i && in_tready_o;
  assign out_hs = full_q && out_tready_i;

  assign dbg_full_o = full_q;
  assign dbg_idx_o  = idx_q;

  // Hold register and sub-beat index: load on input transfer, step or
  // release on output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data_q <= '0;
      hold_keep_q <= '0;
      hold_last_q <= 1'b0;
      full_q      <= 1'b0;
      idx_q       <= '0;
    end else if (in_hs) begin
      hold_data_q <= in_tdata_i;
      hold_keep_q <= in_tkeep_i;
      hold_last_q <= in_tlast_i;
      full_q      <= 1'b1;
      idx_q       <= '0;
    end else if (out_hs) begin
      if (fin) begin
        full_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_width_downsizer_trim.sv
// Bench for axi_width_downsizer_trim at 512 -> 256.
module tb_axi_width_downsizer_trim;

  localparam int IW    = 512;
  localparam int OW    = 256;
  localparam int RATIO = IW / OW;
  localparam int OKB   = OW / 8;
  localparam int EW    = OW + OKB + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IW-1:0]   in_tdata  = '0;
  logic [IW/8-1:0] in_tkeep  = '0;
  logic            in_tlast  = 1'b0;
  logic            in_tvalid = 1'b0;
  logic            in_tready;
  logic [OW-1:0]   out_tdata;
  logic [OKB-1:0]  out_tkeep;
  logic            out_tlast;
  logic            out_tvalid;
  logic            out_tready;
  logic            dbg_full;
  logic [0:0]      dbg_idx;

  logic rdy_rand     = 1'b0;
  logic rdy_fixed    = 1'b1;
  logic rdy_rand_val = 1'b1;
  assign out_tready = rdy_rand ? rdy_rand_val : rdy_fixed;

  // Random output back-pressure, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    rdy_rand_val = 1'($urandom_range(0, 1));
  end

  axi_width_downsizer_trim #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_tdata_i   (in_tdata),
    .in_tkeep_i   (in_tkeep),
    .in_tlast_i   (in_tlast),
    .in_tvalid_i  (in_tvalid),
    .in_tready_o  (in_tready),
    .out_tdata_o  (out_tdata),
    .out_tkeep_o  (out_tkeep),
    .out_tlast_o  (out_tlast),
    .out_tvalid_o (out_tvalid),
    .out_tready_i (out_tready),
    .dbg_full_o   (dbg_full),
    .dbg_idx_o    (dbg_idx)
  );

  // ---------------- check bookkeeping ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic [IW-1:0] rand_data();
    logic [IW-1:0] r;
    for (int i = 0; i < IW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand_keep64();
    logic [63:0] r;
    r[31:0]  = $urandom;
    r[63:32] = $urandom;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  // Reference: a wide beat yields RATIO narrow beats in order; a last beat
  // yields only up to its highest sub-word with any keep bit (minimum one).
  logic [EW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [EW:0]   prev_out   = '0;

  function automatic int beats_for(input logic [IW/8-1:0] k, input logic l);
    int n;
    if (!l) return RATIO;
    n = 1;
    for (int s = 0; s < RATIO; s++) if (k[s*OKB +: OKB] != 0) n = s + 1;
    return n;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_stable", {out_tvalid, out_tdata, out_tkeep, out_tlast}, prev_out);
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_beat", 1'b1, 1'b0);
        else chk("sb_beat", {out_tdata, out_tkeep, out_tlast}, exp_q.pop_front());
      end
      if (in_tvalid && in_tready) begin
        int n;
        n = beats_for(in_tkeep, in_tlast);
        for (int s = 0; s < n; s++)
          exp_q.push_back({in_tdata[s*OW +: OW], in_tkeep[s*OKB +: OKB], in_tlast && (s == n - 1)});
      end
      prev_stall = out_tvalid && !out_tready;
      prev_out   = {out_tvalid, out_tdata, out_tkeep, out_tlast};
    end
  end

  // ---------------- driver ----------------
  // Entered and left just after an active edge; presents one beat and holds
  // it until accepted.
  task automatic drive_beat(input logic [IW-1:0] d, input logic [IW/8-1:0] k,
                            input logic l, input int max_gap);
    int  g;
    bit  ok;
    g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (g) begin
      in_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tkeep  = k;
    in_tlast  = l;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drv_accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_tvalid = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [63:0] keep;
    logic        last;
    int          n;
    logic [31:0] k0;
    logic [31:0] k1;
    int          busy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [IW-1:0] d;
    logic [OW-1:0] ob_data[4];
    logic [OKB-1:0] ob_keep[4];
    logic          ob_last[4];
    int            nb, busy, nl, cnt, started;
    logic          last_seen;

    tbl[0] = '{64'hFFFFFFFF_FFFFFFFF, 1'b0, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1};
    tbl[1] = '{64'h00000000_FFFFFFFF, 1'b1, 1, 32'hFFFFFFFF, 32'h0,        0};
    tbl[2] = '{64'h00000000_00000000, 1'b1, 1, 32'h0,        32'h0,        0};
    tbl[3] = '{64'h0000FFFF_00000000, 1'b0, 2, 32'h0,        32'h0000FFFF, 1};
    tbl[4] = '{64'hFFFFFFFF_FFFFFFFF, 1'b1, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1};
    tbl[5] = '{64'h0000FFFF_00000000, 1'b1, 2, 32'h0,        32'h0000FFFF, 1};
    tbl[6] = '{64'h00000000_0000000F, 1'b1, 1, 32'h0000000F, 32'h0,        0};
    tbl[7] = '{64'h00000000_FFFFFFFF, 1'b0, 2, 32'hFFFFFFFF, 32'h0,        1};

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_tvalid", out_tvalid, 1'b0);
    chk("rst_in_tready",  in_tready,  1'b1);
    chk("rst_out_tdata",  out_tdata,  '0);
    chk("rst_out_tkeep",  out_tkeep,  '0);
    chk("rst_out_tlast",  out_tlast,  1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // table-driven single beats, output always ready
    rdy_fixed = 1'b1;
    foreach (tbl[i]) begin
      d = rand_data();
      drive_beat(d, tbl[i].keep, tbl[i].last, 0);
      nb = 0; busy = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (c == 0) chk("tbl_latency", out_tvalid, 1'b1);
        if (!in_tready) busy++;
        if (out_tvalid && out_tready && nb < 4) begin
          ob_data[nb] = out_tdata;
          ob_keep[nb] = out_tkeep;
          ob_last[nb] = out_tlast;
          nb++;
        end
      end
      chk("tbl_nbeats", nb, tbl[i].n);
      chk("tbl_busy",   busy, tbl[i].busy);
      if (nb >= 1) begin
        chk("tbl_k0", ob_keep[0], tbl[i].k0);
        chk("tbl_d0", ob_data[0], d[OW-1:0]);
        chk("tbl_last_final", ob_last[nb-1], tbl[i].last);
      end
      if (nb >= 2) begin
        chk("tbl_k1", ob_keep[1], tbl[i].k1);
        chk("tbl_d1", ob_data[1], d[IW-1:OW]);
        chk("tbl_last_first", ob_last[0], 1'b0);
      end
      @(posedge clk); #1;
    end

    // trimmed last beat: next beat accepted on the same edge as its only out beat
    d = rand_data();
    drive_beat(d, 64'h00000000_FFFFFFFF, 1'b1, 0);
    d = rand_data();
    in_tvalid = 1'b1; in_tdata = d; in_tkeep = '1; in_tlast = 1'b0;
    @(negedge clk);
    chk("trim_out_valid", out_tvalid, 1'b1);
    chk("trim_out_last",  out_tlast,  1'b1);
    chk("trim_in_ready",  in_tready,  1'b1);
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    @(negedge clk);
    chk("trim_next_valid", out_tvalid, 1'b1);
    chk("trim_next_data",  out_tdata,  d[OW-1:0]);
    repeat (4) @(posedge clk);
    #1;

    // back-to-back 100-beat packet, both sides always ready
    nb = 0; nl = 0; started = 0; last_seen = 1'b0;
    fork
      begin
        for (int b = 0; b < 100; b++) drive_beat(rand_data(), '1, b == 99, 0);
      end
      begin
        for (int t = 0; t < 10; t++) begin
          @(negedge clk);
          if (out_tvalid) begin
            started = 1;
            break;
          end
        end
        if (started != 0) begin
          cnt = 1;
          nb = 1;
          nl = out_tlast ? 1 : 0;
          while (cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (out_tvalid && out_tready) nb++;
            if (out_tvalid && out_tlast) nl++;
            last_seen = out_tlast;
          end
        end
      end
    join
    chk("b2b_started",   started, 1);
    chk("b2b_beats",     nb, 200);
    chk("b2b_tlast_cnt", nl, 1);
    chk("b2b_tlast_pos", last_seen, 1'b1);
    @(negedge clk);
    chk("b2b_idle_after", out_tvalid, 1'b0);
    @(posedge clk); #1;

    // random packets with random back-pressure and input gaps
    rdy_rand = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        logic [63:0] k;
        logic        l;
        l = (b == len - 1);
        if (l) begin
          if ($urandom_range(0, 1) == 0) begin
            int nbytes;
            logic [64:0] ones;
            nbytes = $urandom_range(0, 64);
            ones   = (65'd1 << nbytes) - 65'd1;
            k      = ones[63:0];
          end else begin
            k = rand_keep64();
          end
        end else begin
          k = ($urandom_range(0, 7) == 0) ? rand_keep64() : 64'hFFFFFFFF_FFFFFFFF;
        end
        drive_beat(rand_data(), k, l, ($urandom_range(0, 3) == 0) ? 2 : 0);
      end
    end
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;
    repeat (20) @(negedge clk);
    chk("rand_drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // reset mid-beat while stalled on sub-word 1
    rdy_fixed = 1'b1;
    drive_beat(rand_data(), '1, 1'b0, 0);
    @(posedge clk); #1;
    rdy_fixed = 1'b0;
    @(negedge clk);
    chk("mid_valid_before_rst", out_tvalid, 1'b1);
    chk("mid_idx_before_rst",   dbg_idx,    1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_valid_drop", out_tvalid, 1'b0);
    chk("mid_async_in_ready",   in_tready,  1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_fixed = 1'b1;
    chk("post_rst_in_ready", in_tready, 1'b1);
    chk("post_rst_valid",    out_tvalid, 1'b0);
    d = rand_data();
    drive_beat(d, '1, 1'b1, 0);
    @(negedge clk);
    chk("post_rst_idx0",  dbg_idx,   1'b0);
    chk("post_rst_data0", out_tdata, d[OW-1:0]);
    repeat (4) @(negedge clk);
    chk("post_rst_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $finish;
  end

endmodule
